alu_resp_checker: RTL and testbench
===================================

# alu_resp_checker

Synthesizable response checker at the result end of the 8-bit ALU interface. It observes the operand/select bus driven into the ALU and the registered `ALU_out`/`Carry_out` coming back. It computes the expected result for each observed stimulus, aligns it to the ALU's output latency, and compares every cycle over a programmed window. It reports pass/fail, a saturating mismatch count and the first failing case, so an ALU sweep can be self-checked in silicon or simulation without a behavioural scoreboard.

## Interface
Parameters:
- `LATENCY`, 1, ALU clock-to-result delay in cycles (legal 1..4).
- `NUM_SAMPLES`, 16, compare cycles per run (legal 1..255).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a run; ignored while `busy`.
- `mon_a`  in  8  operand A as presented to the ALU.
- `mon_b`  in  8  operand B as presented to the ALU.
- `mon_sel`  in  4  select as presented to the ALU.
- `mon_out`  in  8  ALU_out.
- `mon_carry`  in  1  Carry_out.
- `busy`  out  1  high in ARM and CHECK.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  1 when the last run had zero mismatches; held until next `start`.
- `err_count`  out  8  mismatches in current/last run, saturates at 255.
- `first_err_sel`  out  4  select of first mismatch.
- `first_err_got`  out  8  `mon_out` at first mismatch.
- `first_err_exp`  out  8  expected value at first mismatch.

## Operation
- Expected result by select (A, B unsigned):
  - 0 A+B[7:0]; 1 A-B[7:0]; 2 A*B[7:0]; 3 A/B (integer).
  - 4 A<<1; 5 A>>1; 6 rotate-left-1 A; 7 rotate-right-1 A.
  - 8 A&B; 9 A|B; 10 A^B; 11 ~(A|B); 12 ~(A&B); 13 ~(A^B).
  - 14 (A>B)?1:0; 15 (A==B)?1:0.
- Expected carry is bit 8 of {0,A}+{0,B} for every select.
- Select 3 with B==0: cycle is not compared and not counted as an error.
- Stimulus (`mon_a`,`mon_b`,`mon_sel`) is delayed through a LATENCY-deep register pipe, so each comparison uses the stimulus sampled LATENCY cycles earlier.
- FSM:
  - IDLE: `start` -> ARM; clears `err_count`, `pass`, first-error fields, sample counter.
  - ARM: fills pipe for LATENCY cycles -> CHECK.
  - CHECK: compares once per cycle for NUM_SAMPLES cycles -> DONE.
  - DONE: one cycle, `done`=1, `pass`=(err_count==0) -> IDLE.
- Mismatch: `err_count`+1, saturating at 255. First-error fields are captured only when `err_count` was 0.
- `start` in ARM/CHECK/DONE is ignored.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `err_count`=0, first-error fields 0, FSM IDLE, pipe cleared.
- `start` sampled at edge N -> `busy`=1 from N+1. The first compare occurs at edge N+1+LATENCY against the stimulus present at edge N+1.
- Run length start-to-`done` edge: 1+LATENCY+NUM_SAMPLES cycles. `busy` falls the same edge `done` rises.
- `err_count` updates on the edge after the failing compare is sampled. The final compare is included in `pass`.
- `rst_n` low mid-run: immediate return to reset values. No `done` is issued.

## Configuration
- `ALU_CHK_CARRY_EN` defined: a cycle mismatches if `mon_out` or `mon_carry` differs from expected.
- Undefined: only `mon_out` is compared; carry logic is removed and `mon_carry` is unused.

## Test plan
- Ideal ALU model (LATENCY=1), A=30, B=20, sel swept 0..15 one per cycle, NUM_SAMPLES=16 -> expected 50,10,88,1,60,15,60,15,20,30,10,0xE1,0xEB,0xF5,1,0 all match; `pass`=1, `err_count`=0, `done` at start+18.
- Model forces sel 9 output to 0x1F -> `err_count`=1, `first_err_sel`=9, `first_err_got`=0x1F, `first_err_exp`=0x1E, `pass`=0.
- A=200, B=100, sel 0, carry forced 0 -> with `ALU_CHK_CARRY_EN` `err_count`=NUM_SAMPLES; without it `pass`=1 (out=44 matches).
- B=0, sel 3, model output 0xFF -> no error counted, `pass`=1.
- NUM_SAMPLES=255, model output always wrong -> `err_count` saturates at 255; `start` pulsed mid-run ignored.
- `rst_n` asserted during CHECK -> all outputs 0 within the same cycle, no `done`; a fresh `start` then completes normally.

Source files
------------

// File: rtl/alu_resp_checker.sv
// alu_resp_checker
// Response checker for the 8-bit ALU. Observes the operand/select bus going
// into the ALU and the registered result coming back. The stimulus is delayed
// by LATENCY cycles, the expected result is computed, and each cycle of a
// programmed window of NUM_SAMPLES compares is checked. Reports pass/fail, a
// saturating mismatch count and the first failing case.
//
// Optional feature macro: ALU_CHK_CARRY_EN
//   defined   : Carry_out is compared as well as ALU_out.
//   undefined : only ALU_out is compared; mon_carry is ignored.
//
// Compare timing: the stimulus that was present at edge N+1 after an accepted
// start at edge N is captured with mon_out at edge N+1+LATENCY. The captured
// pair is scored one edge later, so err_count, pass and done all settle at
// edge N+1+LATENCY+NUM_SAMPLES.

module alu_resp_checker #(
   parameter int LATENCY     = 1,   // ALU clock-to-result delay, 1..4
   parameter int NUM_SAMPLES = 16   // compares per run, 1..255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] mon_a,
   input  logic [7:0] mon_b,
   input  logic [3:0] mon_sel,
   input  logic [7:0] mon_out,
   input  logic       mon_carry,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_count,
   output logic [3:0] first_err_sel,
   output logic [7:0] first_err_got,
   output logic [7:0] first_err_exp
);

   localparam logic [7:0] LAT_LAST = 8'(LATENCY - 1);
   localparam logic [7:0] NS_LAST  = 8'(NUM_SAMPLES);
   localparam logic [3:0] SEL_DIV  = 4'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_CHECK,
      S_DONE
   } state_t;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] sel;
   } stim_t;

   // Expected ALU_out for one stimulus; division by zero yields 0 but is
   // never scored.
   function automatic logic [7:0] exp_result(input logic [7:0] a,
                                             input logic [7:0] b,
                                             input logic [3:0] sel);
      logic [7:0] r;
      r = '0;
      case (sel)
         4'd0:    r = a + b;
         4'd1:    r = a - b;
         4'd2:    r = a * b;
         4'd3:    r = (b == 8'd0) ? 8'd0 : a / b;
         4'd4:    r = {a[6:0], 1'b0};
         4'd5:    r = {1'b0, a[7:1]};
         4'd6:    r = {a[6:0], a[7]};
         4'd7:    r = {a[0], a[7:1]};
         4'd8:    r = a & b;
         4'd9:    r = a | b;
         4'd10:   r = a ^ b;
         4'd11:   r = ~(a | b);
         4'd12:   r = ~(a & b);
         4'd13:   r = ~(a ^ b);
         4'd14:   r = {7'd0, (a > b)};
         default: r = {7'd0, (a == b)};
      endcase
      return r;
   endfunction

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   stim_t      pipe_q [LATENCY];

   state_t     state_q;
   logic [7:0] cnt_q;
   logic       busy_q;
   logic       done_q;
   logic       pass_q;
   logic [7:0] err_q;
   logic [7:0] err_d;
   logic [3:0] fsel_q;
   logic [7:0] fgot_q;
   logic [7:0] fexp_q;

   logic       cap_en;
   logic       valid_q;
   logic       skip_q;
   logic [3:0] sel_q;
   logic [7:0] got_q;
   logic [7:0] exp_q;
   logic       mismatch;

   stim_t      pipe_tail;
   assign pipe_tail = pipe_q[LATENCY-1];

`ifdef ALU_CHK_CARRY_EN
   logic       gcar_q;
   logic       ecar_q;
   logic [8:0] pipe_sum;
   assign pipe_sum = {1'b0, pipe_tail.a} + {1'b0, pipe_tail.b};
`else
   logic       unused_carry;
   assign unused_carry = mon_carry;
`endif

   // Stimulus delay line: each entry is the bus as it was k+1 cycles ago.
   // NOTE: sequential state is written with non-blocking assignments so every
   // stage samples its neighbour's old value and the shift is order-independent.
   // NOTE: this array is reset because a few flops are cheap and the cleared
   // pipe is a defined state; large RAM-style storage would normally be left
   // unreset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= '{a: mon_a, b: mon_b, sel: mon_sel};
         for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   // Capture window: one sample per CHECK cycle until NUM_SAMPLES are taken.
   assign cap_en = (state_q == S_CHECK) && (cnt_q < NS_LAST);

   // Compare stage: register ALU result next to the expected value for it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         skip_q  <= 1'b0;
         sel_q   <= '0;
         got_q   <= '0;
         exp_q   <= '0;
`ifdef ALU_CHK_CARRY_EN
         gcar_q  <= 1'b0;
         ecar_q  <= 1'b0;
`endif
      end else begin
         valid_q <= cap_en;
         if (cap_en) begin
            skip_q <= (pipe_tail.sel == SEL_DIV) && (pipe_tail.b == 8'd0);
            sel_q  <= pipe_tail.sel;
            got_q  <= mon_out;
            exp_q  <= exp_result(pipe_tail.a, pipe_tail.b, pipe_tail.sel);
`ifdef ALU_CHK_CARRY_EN
            gcar_q <= mon_carry;
            ecar_q <= pipe_sum[8];
`endif
         end
      end
   end

`ifdef ALU_CHK_CARRY_EN
   assign mismatch = valid_q && !skip_q && ((got_q != exp_q) || (gcar_q != ecar_q));
`else
   assign mismatch = valid_q && !skip_q && (got_q != exp_q);
`endif

   // Saturating next value of the mismatch counter.
   // NOTE: the default assignment first keeps every path assigned, so no
   // latch is inferred.
   always_comb begin
      err_d = err_q;
      if (mismatch && (err_q != 8'hFF)) err_d = err_q + 8'd1;
   end

   // Run sequencer with registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         fsel_q  <= '0;
         fgot_q  <= '0;
         fexp_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_ARM;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  pass_q  <= 1'b0;
                  err_q   <= '0;
                  fsel_q  <= '0;
                  fgot_q  <= '0;
                  fexp_q  <= '0;
               end
            end
            S_ARM: begin
               if (cnt_q == LAT_LAST) begin
                  state_q <= S_CHECK;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_CHECK: begin
               err_q <= err_d;
               if (mismatch && (err_q == 8'd0)) begin
                  fsel_q <= sel_q;
                  fgot_q <= got_q;
                  fexp_q <= exp_q;
               end
               // Last cycle scores the final captured sample, then reports.
               if (cnt_q == NS_LAST) begin
                  state_q <= S_DONE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (err_d == 8'd0);
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign err_count     = err_q;
   assign first_err_sel = fsel_q;
   assign first_err_got = fgot_q;
   assign first_err_exp = fexp_q;

endmodule

// File: tb/tb_alu_resp_checker.sv
// Testbench for alu_resp_checker. Two checkers watch a shared stimulus bus:
// u_dut0 (LATENCY=1, NUM_SAMPLES=16) and u_dut1 (LATENCY=3, NUM_SAMPLES=255),
// each fed by a behavioural ALU of matching latency with injectable faults.
// Expected results come from an arithmetic reference of the ALU and a
// per-run scoreboard over the stimulus list.

module tb_alu_resp_checker;

`ifdef ALU_CHK_CARRY_EN
   localparam bit CARRY_EN = 1'b1;
`else
   localparam bit CARRY_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic [1:0] start_v;
   logic [7:0] mon_a, mon_b;
   logic [3:0] mon_sel;

   logic [1:0]      busy_v, done_v, pass_v;
   logic [1:0][7:0] err_v, fgot_v, fexp_v;
   logic [1:0][3:0] fsel_v;

   // Fault knobs for the ALU model.
   bit       flt_en, flt_inv, flt_c0;
   bit [3:0] flt_sel;
   bit [7:0] flt_val;

   // Stimulus list for the compare window of a run.
   bit [7:0] sa [256];
   bit [7:0] sb [256];
   bit [3:0] ss [256];

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int         done_e;
      bit         busy_ok;
      logic       busy_at_done;
      logic       pass_at_start;
      logic       pass;
      logic [7:0] err;
      logic [3:0] fsel;
      logic [7:0] fgot;
      logic [7:0] fexp;
      logic       done_after;
      logic       pass_after;
   } obs_t;

   typedef struct {
      int err;
      int fsel;
      int fgot;
      int fexp;
      bit pass;
   } exp_t;

   always #5 clk = ~clk;

   // Reference ALU: {carry, result} computed with plain integer arithmetic.
   function automatic logic [8:0] ref_alu(input int a, input int b, input int sel);
      int r;
      case (sel)
         0:  r = (a + b) % 256;
         1:  r = (a - b + 256) % 256;
         2:  r = (a * b) % 256;
         3:  r = (b == 0) ? 0 : a / b;
         4:  r = (a * 2) % 256;
         5:  r = a / 2;
         6:  r = (a * 2) % 256 + a / 128;
         7:  r = a / 2 + (a % 2) * 128;
         8:  r = a & b;
         9:  r = a | b;
         10: r = a ^ b;
         11: r = 255 - (a | b);
         12: r = 255 - (a & b);
         13: r = 255 - (a ^ b);
         14: r = (a > b) ? 1 : 0;
         default: r = (a == b) ? 1 : 0;
      endcase
      return {((a + b) > 255) ? 1'b1 : 1'b0, 8'(r)};
   endfunction

   // ALU under observation: reference plus whatever fault is switched on.
   function automatic logic [8:0] model_alu(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] sel);
      logic [8:0] r;
      r = ref_alu(a, b, sel);
      if (flt_en && sel == flt_sel) r[7:0] = flt_val;
      if (flt_inv) r[7:0] = ~r[7:0];
      if (flt_c0) r[8] = 1'b0;
      return r;
   endfunction

   logic [8:0] res_pipe [4] = '{default: '0};

   always @(posedge clk) begin
      res_pipe[0] <= model_alu(mon_a, mon_b, mon_sel);
      for (int i = 1; i < 4; i++) res_pipe[i] <= res_pipe[i-1];
   end

   logic [8:0] alu0, alu1;
   assign alu0 = res_pipe[0];
   assign alu1 = res_pipe[2];

   alu_resp_checker #(.LATENCY(1), .NUM_SAMPLES(16)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]),
      .mon_a(mon_a), .mon_b(mon_b), .mon_sel(mon_sel),
      .mon_out(alu0[7:0]), .mon_carry(alu0[8]),
      .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_v[0]),
      .first_err_sel(fsel_v[0]), .first_err_got(fgot_v[0]), .first_err_exp(fexp_v[0])
   );

   alu_resp_checker #(.LATENCY(3), .NUM_SAMPLES(255)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]),
      .mon_a(mon_a), .mon_b(mon_b), .mon_sel(mon_sel),
      .mon_out(alu1[7:0]), .mon_carry(alu1[8]),
      .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err_v[1]),
      .first_err_sel(fsel_v[1]), .first_err_got(fgot_v[1]), .first_err_exp(fexp_v[1])
   );

   task automatic clear_faults();
      flt_en = 0; flt_inv = 0; flt_c0 = 0; flt_sel = '0; flt_val = '0;
   endtask

   task automatic fill_const(input bit [7:0] a, input bit [7:0] b, input bit sweep,
                             input bit [3:0] sel);
      for (int k = 0; k < 256; k++) begin
         sa[k] = a; sb[k] = b; ss[k] = sweep ? 4'(k) : sel;
      end
   endtask

   // Scoreboard: expected outcome of a run from the stimulus list and faults.
   task automatic score(input int ns, output exp_t x);
      logic [8:0] m, r;
      bit mm;
      x = '{default: 0};
      for (int k = 0; k < ns; k++) begin
         m = model_alu(sa[k], sb[k], ss[k]);
         r = ref_alu(sa[k], sb[k], ss[k]);
         mm = (m[7:0] != r[7:0]) || (CARRY_EN && m[8] != r[8]);
         if (ss[k] == 4'd3 && sb[k] == 8'd0) mm = 0;
         if (mm) begin
            if (x.err == 0) begin
               x.fsel = ss[k]; x.fgot = m[7:0]; x.fexp = r[7:0];
            end
            if (x.err < 255) x.err++;
         end
      end
      x.pass = (x.err == 0);
   endtask

   // Start one checker, feed the stimulus list, and record what it reports.
   task automatic do_run(input int which, input int ns, input int lat, input bit poke,
                         output obs_t o);
      int  e;
      bit  seen;
      o = '{default: 0};
      o.done_e = -1;
      o.busy_ok = 1;
      @(negedge clk);
      start_v[which] = 1'b1;
      @(negedge clk);
      start_v[which] = 1'b0;
      if (busy_v[which] !== 1'b1) o.busy_ok = 0;
      o.pass_at_start = pass_v[which];
      mon_a = sa[0]; mon_b = sb[0]; mon_sel = ss[0];
      e = 0;
      seen = 0;
      while (!seen && e < ns + lat + 20) begin
         @(negedge clk);
         e++;
         if (done_v[which] === 1'b1) begin
            seen = 1;
            o.done_e = e;
            o.busy_at_done = busy_v[which];
            o.pass = pass_v[which];
            o.err  = err_v[which];
            o.fsel = fsel_v[which];
            o.fgot = fgot_v[which];
            o.fexp = fexp_v[which];
         end else begin
            if (busy_v[which] !== 1'b1) o.busy_ok = 0;
            start_v[which] = poke && (e == lat + 3);
            if (e < ns) begin
               mon_a = sa[e]; mon_b = sb[e]; mon_sel = ss[e];
            end else begin
               mon_a = 8'($urandom); mon_b = 8'($urandom); mon_sel = 4'($urandom);
            end
         end
      end
      start_v[which] = 1'b0;
      @(negedge clk);
      o.done_after = done_v[which];
      o.pass_after = pass_v[which];
   endtask

   task automatic test_reset();
      logic [32:0] s0, s1;
      s0 = {busy_v[0], done_v[0], pass_v[0], err_v[0], fsel_v[0], fgot_v[0], fexp_v[0]};
      s1 = {busy_v[1], done_v[1], pass_v[1], err_v[1], fsel_v[1], fgot_v[1], fexp_v[1]};
      checks++;
      if (s0 !== '0) begin failures++; $display("FAIL reset_dut0: got %h expected 0", s0); end
      checks++;
      if (s1 !== '0) begin failures++; $display("FAIL reset_dut1: got %h expected 0", s1); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      s0 = {busy_v[0], done_v[0], pass_v[0], err_v[0], fsel_v[0], fgot_v[0], fexp_v[0]};
      checks++;
      if (s0 !== '0) begin failures++; $display("FAIL post_reset_idle: got %h expected 0", s0); end
   endtask

   task automatic test_sweep();
      obs_t o;
      clear_faults();
      fill_const(8'd30, 8'd20, 1'b1, 4'd0);
      do_run(0, 16, 1, 0, o);
      checks++;
      if (o.done_e != 18) begin failures++; $display("FAIL sweep_done_cycle: got %0d expected 18", o.done_e); end
      checks++;
      if (!o.busy_ok || o.busy_at_done !== 1'b0) begin
         failures++; $display("FAIL sweep_busy: got ok=%0d at_done=%b expected ok=1 at_done=0", o.busy_ok, o.busy_at_done);
      end
      checks++;
      if (o.pass !== 1'b1 || o.err !== 8'd0) begin
         failures++; $display("FAIL sweep_result: got pass=%b err=%0d expected pass=1 err=0", o.pass, o.err);
      end
      checks++;
      if (o.done_after !== 1'b0 || o.pass_after !== 1'b1) begin
         failures++; $display("FAIL sweep_pulse_hold: got done=%b pass=%b expected done=0 pass=1", o.done_after, o.pass_after);
      end
   endtask

   task automatic test_first_error();
      obs_t o;
      clear_faults();
      flt_en = 1; flt_sel = 4'd9; flt_val = 8'h1F;
      fill_const(8'd30, 8'd20, 1'b1, 4'd0);
      do_run(0, 16, 1, 0, o);
      checks++;
      if (o.pass_at_start !== 1'b0) begin failures++; $display("FAIL pass_cleared_on_start: got %b expected 0", o.pass_at_start); end
      checks++;
      if (o.err !== 8'd1 || o.pass !== 1'b0) begin
         failures++; $display("FAIL sel9_count: got err=%0d pass=%b expected err=1 pass=0", o.err, o.pass);
      end
      checks++;
      if (o.fsel !== 4'd9 || o.fgot !== 8'h1F || o.fexp !== 8'h1E) begin
         failures++; $display("FAIL sel9_first: got sel=%0d got=%h exp=%h expected sel=9 got=1f exp=1e", o.fsel, o.fgot, o.fexp);
      end
   endtask

   task automatic test_carry();
      obs_t o;
      int   e_err;
      clear_faults();
      flt_c0 = 1;
      fill_const(8'd200, 8'd100, 1'b0, 4'd0);
      e_err = CARRY_EN ? 16 : 0;
      do_run(0, 16, 1, 0, o);
      checks++;
      if (o.err != 8'(e_err) || o.pass !== !CARRY_EN) begin
         failures++; $display("FAIL carry_forced: got err=%0d pass=%b expected err=%0d pass=%0d", o.err, o.pass, e_err, !CARRY_EN);
      end
   endtask

   task automatic test_div_zero();
      obs_t o;
      clear_faults();
      flt_en = 1; flt_sel = 4'd3; flt_val = 8'hFF;
      fill_const(8'($urandom), 8'd0, 1'b0, 4'd3);
      do_run(0, 16, 1, 0, o);
      checks++;
      if (o.err !== 8'd0 || o.pass !== 1'b1) begin
         failures++; $display("FAIL div_zero_skip: got err=%0d pass=%b expected err=0 pass=1", o.err, o.pass);
      end
   endtask

   task automatic test_random();
      obs_t o;
      exp_t x;
      for (int r = 0; r < 6; r++) begin
         clear_faults();
         flt_en  = 1'($urandom);
         flt_sel = 4'($urandom);
         flt_val = 8'($urandom);
         flt_c0  = ($urandom_range(0, 2) == 0);
         for (int k = 0; k < 256; k++) begin
            sa[k] = 8'($urandom); sb[k] = 8'($urandom); ss[k] = 4'($urandom);
            if ($urandom_range(0, 7) == 0) begin ss[k] = 4'd3; sb[k] = 8'd0; end
         end
         score(16, x);
         do_run(0, 16, 1, 0, o);
         checks++;
         if (o.done_e != 18 || o.err != 8'(x.err) || o.pass !== x.pass) begin
            failures++;
            $display("FAIL random_%0d_summary: got done@%0d err=%0d pass=%b expected done@18 err=%0d pass=%0d",
                     r, o.done_e, o.err, o.pass, x.err, x.pass);
         end
         checks++;
         if (o.fsel != 4'(x.fsel) || o.fgot != 8'(x.fgot) || o.fexp != 8'(x.fexp)) begin
            failures++;
            $display("FAIL random_%0d_first: got sel=%0d got=%h exp=%h expected sel=%0d got=%h exp=%h",
                     r, o.fsel, o.fgot, o.fexp, x.fsel, x.fgot, x.fexp);
         end
      end
   endtask

   task automatic test_saturate();
      obs_t o;
      exp_t x;
      clear_faults();
      flt_inv = 1;
      for (int k = 0; k < 256; k++) begin
         sa[k] = 8'($urandom); sb[k] = 8'($urandom); ss[k] = 4'($urandom);
         if (ss[k] == 4'd3) sb[k] = sb[k] | 8'd1;
      end
      score(255, x);
      do_run(1, 255, 3, 1, o);
      checks++;
      if (o.done_e != 259) begin failures++; $display("FAIL sat_done_cycle_mid_start: got %0d expected 259", o.done_e); end
      checks++;
      if (o.err !== 8'd255 || o.pass !== 1'b0) begin
         failures++; $display("FAIL sat_count: got err=%0d pass=%b expected err=255 pass=0", o.err, o.pass);
      end
      checks++;
      if (o.fsel != 4'(x.fsel) || o.fgot != 8'(x.fgot) || o.fexp != 8'(x.fexp)) begin
         failures++;
         $display("FAIL sat_first: got sel=%0d got=%h exp=%h expected sel=%0d got=%h exp=%h",
                  o.fsel, o.fgot, o.fexp, x.fsel, x.fgot, x.fexp);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [32:0] s0;
      bit          saw_done;
      obs_t        o;
      clear_faults();
      flt_inv = 1;
      mon_a = 8'd30; mon_b = 8'd20; mon_sel = 4'd0;
      @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      s0 = {busy_v[0], done_v[0], pass_v[0], err_v[0], fsel_v[0], fgot_v[0], fexp_v[0]};
      checks++;
      if (s0 !== '0) begin failures++; $display("FAIL mid_run_reset: got %h expected 0", s0); end
      @(negedge clk);
      rst_n = 1'b1;
      saw_done = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (done_v[0] !== 1'b0) saw_done = 1;
      end
      checks++;
      if (saw_done) begin failures++; $display("FAIL no_done_after_reset: got done=1 expected done=0"); end
      clear_faults();
      fill_const(8'd30, 8'd20, 1'b1, 4'd0);
      do_run(0, 16, 1, 0, o);
      checks++;
      if (o.done_e != 18 || o.pass !== 1'b1 || o.err !== 8'd0) begin
         failures++; $display("FAIL rerun_after_reset: got done@%0d pass=%b err=%0d expected done@18 pass=1 err=0", o.done_e, o.pass, o.err);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      start_v = '0;
      mon_a   = '0;
      mon_b   = '0;
      mon_sel = '0;
      clear_faults();
      repeat (3) @(negedge clk);
      test_reset();
      test_sweep();
      test_first_error();
      test_carry();
      test_div_zero();
      test_random();
      test_saturate();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
